// File: rtl/alu_issue_unit.sv
// alu_issue_unit: operand-issue and writeback stage in front of an 8-bit ALU, with a 4 x 8-bit register file.
// Latency: alu_a/alu_b/alu_op are valid one edge after accept; writeback and res_valid follow one edge later; 3 cycles per instruction.
// Backpressure: instr_ready is low outside IDLE and whenever ld_en is high; ld_en outside IDLE is dropped, not queued.
//
// Ports:
//   clk, rst_n              single clock, synchronous active-low reset
//   instr_valid/instr_ready instruction handshake; instr = {op[2:0], rd[1:0], rs1[1:0], rs2[1:0]}
//   ld_en/ld_addr/ld_data   external register-file load, applied only in IDLE, wins over an instruction
//   alu_a/alu_b/alu_op      registered operands and opcode driven to the ALU
//   alu_out                 combinational ALU result, captured at the end of ISSUE
//   res_valid/res_data/res_rd  one-cycle writeback strobe, written value (held) and its destination
//   retired                 retired-instruction count, wraps modulo 256
module alu_issue_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [8:0] instr,
    output logic       instr_ready,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_out,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic [1:0] res_rd,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    state_t     state;
    state_t     state_nxt;
    instr_t     ins;
    logic [7:0] rf [0:3];
    logic [1:0] rd_q;
    logic       ld_wr;
    logic       accept;
    logic       wb_wr;

    assign ins = instr_t'(instr);

    // Ready looks only at state and ld_en so upstream can never form a loop through instr_valid.
    assign instr_ready = (state == IDLE) && !ld_en;
    assign accept      = instr_ready && instr_valid;
    assign ld_wr       = (state == IDLE) && ld_en;
    assign wb_wr       = (state == ISSUE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file: an external load and a writeback can never coincide,
    // since loads only land in IDLE and writebacks only in ISSUE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 8'h00;
            end
        end else if (ld_wr) begin
            rf[ld_addr] <= ld_data;
        end else if (wb_wr) begin
            rf[rd_q] <= alu_out;
        end
    end

    // ------------------------------------------------------------------
    // Operand issue: operands are read at accept time, so rd may alias
    // rs1/rs2 and still see the pre-instruction value. The ALU inputs
    // then hold until the next accept.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
            alu_op <= 3'b111;
            rd_q   <= 2'd0;
        end else if (accept) begin
            alu_a  <= rf[ins.rs1];
            alu_b  <= rf[ins.rs2];
            alu_op <= ins.op;
            rd_q   <= ins.rd;
        end
    end

    // ------------------------------------------------------------------
    // Writeback reporting: res_valid rises with the writeback edge and
    // falls at the WB -> IDLE edge; res_data/res_rd hold until the next
    // writeback.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_rd    <= 2'd0;
            retired   <= 8'h00;
        end else begin
            if (wb_wr) begin
                res_valid <= 1'b1;
                res_data  <= alu_out;
                res_rd    <= rd_q;
                retired   <= retired + 8'd1;
            end else if (state == WB) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       res_valid;
    logic [7:0] res_data;
    logic [1:0] res_rd;
    logic [7:0] retired;

    int total = 0;
    int bad   = 0;

    alu_issue_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in. MUL multiplies the low nibbles (0xFF*0xFF -> 0xE1); opcode 7 yields 0.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [7:0] r;
        case (op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = {a[6:0], 1'b0};
            3'd6:    r = a[3:0] * b[3:0];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction view. An accepted instruction's result
    // is computed at accept from the model's own register file and retires
    // after a fixed countdown.
    // ------------------------------------------------------------------
    logic [7:0] m_rf [0:3];
    logic [7:0] m_a, m_b, m_rdat, m_pend_val;
    logic [2:0] m_op;
    logic [1:0] m_rd_out, m_pend_rd;
    logic       m_rv;
    int         m_ret;
    int         m_busy;      // cycles left before the unit is free again
    bit         model_ok = 0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
            m_a = 0; m_b = 0; m_op = 3'b111;
            m_rv = 0; m_rdat = 0; m_rd_out = 0; m_ret = 0;
            m_busy = 0; m_pend_rd = 0; m_pend_val = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (m_busy == 0) begin
                if (ld_en) begin
                    m_rf[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    m_a        = m_rf[instr[3:2]];
                    m_b        = m_rf[instr[1:0]];
                    m_op       = instr[8:6];
                    m_pend_rd  = instr[5:4];
                    m_pend_val = alu_fn(m_a, m_b, m_op);
                    m_busy     = 2;
                end
            end else if (m_busy == 2) begin
                m_rf[m_pend_rd] = m_pend_val;
                m_rdat   = m_pend_val;
                m_rd_out = m_pend_rd;
                m_rv     = 1;
                m_ret    = (m_ret + 1) % 256;
                m_busy   = 1;
            end else begin
                m_rv   = 0;
                m_busy = 0;
            end
        end
    end

    bit wrap_on    = 0;
    int pulses     = 0;
    int last_pulse = -1;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("instr_ready", 32'(instr_ready), 32'(m_busy == 0 && !ld_en));
            chk("alu_a", 32'(alu_a), 32'(m_a));
            chk("alu_b", 32'(alu_b), 32'(m_b));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("res_valid", 32'(res_valid), 32'(m_rv));
            chk("res_data", 32'(res_data), 32'(m_rdat));
            chk("res_rd", 32'(res_rd), 32'(m_rd_out));
            chk("retired", 32'(retired), 32'(m_ret));
        end
        if (wrap_on && res_valid === 1'b1) begin
            if (last_pulse >= 0) chk("pulse_gap", 32'(cyc - last_pulse), 32'd3);
            last_pulse = cyc;
            pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers (called with the unit in IDLE, #1 after an edge)
    // ------------------------------------------------------------------
    task automatic do_load(input logic [1:0] a, input logic [7:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input bit ld_mid,
                         output logic [7:0] a_s, output logic [7:0] b_s,
                         output logic [7:0] r_dat, output logic [1:0] r_rd, output logic r_vld);
        int n = 0;
        instr = {op, rd, rs1, rs2};
        instr_valid = 1;
        @(negedge clk);
        while (instr_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (instr_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
        end
        @(posedge clk); #1;
        instr_valid = 0;
        if (ld_mid) begin
            ld_en = 1; ld_addr = 2'd3; ld_data = 8'hAA;
        end
        a_s = alu_a; b_s = alu_b;
        @(posedge clk); #1;
        ld_en = 0;
        r_vld = res_valid; r_dat = res_data; r_rd = res_rd;
        @(posedge clk); #1;
    endtask

    logic [7:0] a_s, b_s, r_dat;
    logic [1:0] r_rd;
    logic       r_vld;
    int         guard;

    initial begin
        rst_n = 0; instr_valid = 0; instr = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_alu_a", 32'(alu_a), 32'h00);
        chk("rst_alu_op", 32'(alu_op), 32'h7);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_retired", 32'(retired), 32'h00);
        chk("rst_ready", 32'(instr_ready), 32'h1);
        @(posedge clk); #1;

        // ADD R2 = R0 + R1
        do_load(2'd0, 8'h05);
        do_load(2'd1, 8'h03);
        issue(3'd0, 2'd2, 2'd0, 2'd1, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("add_alu_a", 32'(a_s), 32'h05);
        chk("add_alu_b", 32'(b_s), 32'h03);
        chk("add_res_valid", 32'(r_vld), 32'h1);
        chk("add_res_data", 32'(r_dat), 32'h08);
        chk("add_res_rd", 32'(r_rd), 32'h2);
        chk("add_retired", 32'(retired), 32'h01);

        // SUB R3 = R1 - R0 ; MUL with both operands 0xFF
        issue(3'd1, 2'd3, 2'd1, 2'd0, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("sub_res_data", 32'(r_dat), 32'hFE);
        do_load(2'd0, 8'hFF);
        do_load(2'd1, 8'hFF);
        issue(3'd6, 2'd2, 2'd0, 2'd1, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("mul_res_data", 32'(r_dat), 32'hE1);

        // Load and instruction presented together: load wins, instruction follows
        ld_en = 1; ld_addr = 2'd0; ld_data = 8'h07;
        instr = {3'd0, 2'd1, 2'd0, 2'd0}; instr_valid = 1;
        @(negedge clk);
        chk("ld_prio_ready", 32'(instr_ready), 32'h0);
        @(posedge clk); #1;
        ld_en = 0;
        @(negedge clk);
        chk("ld_prio_ready_after", 32'(instr_ready), 32'h1);
        @(posedge clk); #1;
        instr_valid = 0;
        chk("ld_prio_alu_a", 32'(alu_a), 32'h07);
        repeat (2) @(posedge clk);
        #1 chk("ld_prio_res", 32'(res_data), 32'h0E);

        // Load during ISSUE is dropped: R3 keeps 0xFE
        issue(3'd0, 2'd0, 2'd3, 2'd3, 1, a_s, b_s, r_dat, r_rd, r_vld);
        chk("ld_issue_res", 32'(r_dat), 32'hFC);
        issue(3'd2, 2'd2, 2'd3, 2'd3, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("ld_issue_r3", 32'(a_s), 32'hFE);

        // Self-alias, back to back
        do_load(2'd0, 8'h04);
        issue(3'd0, 2'd0, 2'd0, 2'd0, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("alias_1", 32'(r_dat), 32'h08);
        issue(3'd0, 2'd0, 2'd0, 2'd0, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("alias_2", 32'(r_dat), 32'h10);

        // Reset during ISSUE drops the instruction
        do_load(2'd1, 8'h33);
        instr = {3'd0, 2'd1, 2'd1, 2'd1}; instr_valid = 1;
        @(negedge clk);
        chk("rst_issue_ready", 32'(instr_ready), 32'h1);
        @(posedge clk); #1;
        instr_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_issue_no_pulse", 32'(res_valid), 32'h0);
        end
        chk("rst_issue_alu_op", 32'(alu_op), 32'h7);
        chk("rst_issue_retired", 32'(retired), 32'h00);
        @(posedge clk); #1;
        issue(3'd0, 2'd0, 2'd1, 2'd1, 0, a_s, b_s, r_dat, r_rd, r_vld);
        chk("rst_issue_r1_cleared", 32'(a_s), 32'h00);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            ld_en       = ($urandom_range(0, 3) == 0);
            ld_addr     = 2'($urandom_range(0, 3));
            ld_data     = 8'($urandom);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = 9'($urandom);
            @(posedge clk); #1;
        end
        rst_n = 1; ld_en = 0; instr_valid = 0;

        // 256 retirements: counter wraps, pulses exactly 3 cycles apart
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        pulses = 0; last_pulse = -1; wrap_on = 1;
        instr_valid = 1;
        guard = 0;
        while (pulses < 256 && guard < 2000) begin
            instr = 9'($urandom);
            @(posedge clk); #1;
            guard++;
        end
        instr_valid = 0;
        @(negedge clk);
        wrap_on = 0;
        chk("wrap_pulses", 32'(pulses), 32'd256);
        chk("wrap_retired", 32'(retired), 32'h00);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
